// File: rtl/db15_serial_reader.sv
// Serial DB15 joystick adapter reader: clocks 32 bits out of the adapter's shift chain and publishes two active-high 16-bit words.
// Optional macro DB15_DEBOUNCE_EN: publish a frame only when it matches the previous captured frame.
`timescale 1ns/1ps

module db15_serial_reader #(
   parameter int CLK_DIV   = 64,
   parameter int FRAME_GAP = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        joy_data,
   output logic        joy_clk,
   output logic        joy_load,
   output logic [15:0] joystick1,
   output logic [15:0] joystick2,
   output logic        frame_done
);

   localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int GAP_W = $clog2(FRAME_GAP + 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      HI,
      LO,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  divCnt_q, divCnt_d;
   logic [GAP_W-1:0]  gapCnt_q, gapCnt_d;
   logic [4:0]        bitIdx_q, bitIdx_d;
   logic [31:0]       sr_q, sr_d;
   logic              dataIn_q;
   logic              joyClk_q, joyClk_d;
   logic              joyLoad_q, joyLoad_d;
   logic [15:0]       joy1_q, joy1_d;
   logic [15:0]       joy2_q, joy2_d;
   logic              frameDone_q, frameDone_d;
   logic              tick;
   logic              acceptFrame;

   assign tick = (divCnt_q == DIV_W'(CLK_DIV - 1));

`ifdef DB15_DEBOUNCE_EN
   logic [31:0] prev_q, prev_d;

   // A frame is only trusted once two consecutive captures agree.
   always_comb begin
      prev_d      = prev_q;
      acceptFrame = (sr_q == prev_q);
      if (state_d == DONE) begin
         prev_d = sr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q <= 32'hFFFF_FFFF;
      end else begin
         prev_q <= prev_d;
      end
   end
`else
   assign acceptFrame = 1'b1;
`endif

   // Sequencer: every transition except DONE->IDLE waits for a divider tick.
   always_comb begin
      divCnt_d = tick ? '0 : divCnt_q + DIV_W'(1);
      state_d  = state_q;
      gapCnt_d = gapCnt_q;
      bitIdx_d = bitIdx_q;
      sr_d     = sr_q;
      unique case (state_q)
         IDLE: begin
            if (tick) begin
               if (gapCnt_q == GAP_W'(FRAME_GAP - 1)) begin
                  gapCnt_d = '0;
                  state_d  = LOAD;
               end else begin
                  gapCnt_d = gapCnt_q + GAP_W'(1);
               end
            end
         end
         LOAD: begin
            if (tick) begin
               bitIdx_d = 5'd0;
               state_d  = HI;
            end
         end
         HI: begin
            if (tick) begin
               sr_d[bitIdx_q] = dataIn_q;
               state_d        = LO;
            end
         end
         LO: begin
            if (tick) begin
               if (bitIdx_q == 5'd31) begin
                  state_d = DONE;
               end else begin
                  bitIdx_d = bitIdx_q + 5'd1;
                  state_d  = HI;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Pins and output words are registered from the next state so they change with the state itself.
   always_comb begin
      joyClk_d    = (state_d != LO);
      joyLoad_d   = (state_d != LOAD);
      joy1_d      = joy1_q;
      joy2_d      = joy2_q;
      frameDone_d = 1'b0;
      if ((state_d == DONE) && acceptFrame) begin
         joy1_d      = ~sr_q[15:0];
         joy2_d      = ~sr_q[31:16];
         frameDone_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         divCnt_q    <= '0;
         gapCnt_q    <= '0;
         bitIdx_q    <= 5'd0;
         sr_q        <= 32'd0;
         dataIn_q    <= 1'b1;
         joyClk_q    <= 1'b1;
         joyLoad_q   <= 1'b1;
         joy1_q      <= 16'd0;
         joy2_q      <= 16'd0;
         frameDone_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         divCnt_q    <= divCnt_d;
         gapCnt_q    <= gapCnt_d;
         bitIdx_q    <= bitIdx_d;
         sr_q        <= sr_d;
         dataIn_q    <= joy_data;
         joyClk_q    <= joyClk_d;
         joyLoad_q   <= joyLoad_d;
         joy1_q      <= joy1_d;
         joy2_q      <= joy2_d;
         frameDone_q <= frameDone_d;
      end
   end

   assign joy_clk    = joyClk_q;
   assign joy_load   = joyLoad_q;
   assign joystick1  = joy1_q;
   assign joystick2  = joy2_q;
   assign frame_done = frameDone_q;

endmodule

// File: tb/tb_db15_serial_reader.sv
// Directed bench for db15_serial_reader with a behavioural model of two cascaded 74HC165 shift registers.
`timescale 1ns/1ps

module tb_db15_serial_reader;

   localparam int CLK_DIV   = 4;
   localparam int FRAME_GAP = 2;
   localparam int FRAME_CYC = CLK_DIV * (FRAME_GAP + 1 + 64);
   localparam int GAP_CYC   = CLK_DIV * FRAME_GAP;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        joy_data;
   logic        joy_clk;
   logic        joy_load;
   logic [15:0] joystick1;
   logic [15:0] joystick2;
   logic        frame_done;

   logic [15:0] p1 = 16'hFFFF;
   logic [15:0] p2 = 16'hFFFF;
   logic [31:0] chain = 32'hFFFF_FFFF;
   int          tieMode = 0;

   int checks = 0;
   int errors = 0;
   int cycleCnt = 0;
   int risingCnt = 0;
   int doneCnt = 0;
   int overlapCnt = 0;

   db15_serial_reader #(
      .CLK_DIV(CLK_DIV),
      .FRAME_GAP(FRAME_GAP)
   ) dut (
      .clk(clk),
      .reset(reset),
      .joy_data(joy_data),
      .joy_clk(joy_clk),
      .joy_load(joy_load),
      .joystick1(joystick1),
      .joystick2(joystick2),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Adapter model: parallel load while joy_load is low, shift toward bit 0 on joy_clk rising, serial-in tied high.
   always @(negedge joy_load or posedge joy_clk) begin
      if (!joy_load) begin
         chain <= {p2, p1};
      end else begin
         chain <= {1'b1, chain[31:1]};
      end
   end

   assign joy_data = (tieMode == 1) ? 1'b0 : (tieMode == 2) ? 1'b1 : chain[0];

   always @(posedge clk) cycleCnt++;
   always @(posedge joy_clk) risingCnt++;

   always @(negedge clk) begin
      if (frame_done === 1'b1) doneCnt++;
      if (!reset && joy_load === 1'b0 && joy_clk === 1'b0) overlapCnt++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] player1, input logic [15:0] player2);
      p1 = player1;
      p2 = player2;
   endtask

   task automatic waitFrameDone(output int waited);
      waited = 0;
      @(negedge clk);
      waited++;
      while (frame_done !== 1'b1 && waited < 2 * FRAME_CYC) begin
         @(negedge clk);
         waited++;
      end
      if (frame_done !== 1'b1) checkOutput("frameDoneTimeout", {31'd0, frame_done}, 32'd1);
   endtask

   task automatic waitLoadLevel(input logic level, output int waited);
      waited = 0;
      @(negedge clk);
      waited++;
      while (joy_load !== level && waited < 2 * FRAME_CYC) begin
         @(negedge clk);
         waited++;
      end
      if (joy_load !== level) checkOutput("joyLoadTimeout", {31'd0, joy_load}, {31'd0, level});
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "Joy1"}, {16'd0, joystick1}, 32'd0);
      checkOutput({tag, "Joy2"}, {16'd0, joystick2}, 32'd0);
      checkOutput({tag, "Done"}, {31'd0, frame_done}, 32'd0);
      checkOutput({tag, "JoyClk"}, {31'd0, joy_clk}, 32'd1);
      checkOutput({tag, "JoyLoad"}, {31'd0, joy_load}, 32'd1);
   endtask

`ifndef DB15_DEBOUNCE_EN
   task automatic runMainTests();
      int w;
      int relCycle;
      int riseBase;
      int lastDone;
      int lowCyc;
      int doneBefore;

      applyStimulus(16'hFFFE, 16'h7FFF);
      @(negedge clk);
      reset = 1'b0;
      relCycle = cycleCnt;
      riseBase = risingCnt;
      waitLoadLevel(1'b0, w);
      checkOutput("firstLoadDelay", cycleCnt - relCycle, GAP_CYC);
      lowCyc = 0;
      while (joy_load === 1'b0 && lowCyc < 20) begin
         lowCyc++;
         @(negedge clk);
      end
      checkOutput("loadLowWidth", lowCyc, CLK_DIV);

      waitFrameDone(w);
      checkOutput("frame1Joy1", {16'd0, joystick1}, 32'h0001);
      checkOutput("frame1Joy2", {16'd0, joystick2}, 32'h8000);
      checkOutput("frame1Rises", risingCnt - riseBase, 32);
      lastDone = cycleCnt;
      @(negedge clk);
      checkOutput("donePulseWidth", {31'd0, frame_done}, 32'd0);
      checkOutput("frame1Hold", {16'd0, joystick1}, 32'h0001);

      for (int f = 0; f < 3; f++) begin
         riseBase = risingCnt;
         waitFrameDone(w);
         checkOutput("frameSpacing", cycleCnt - lastDone, FRAME_CYC);
         checkOutput("frameRises", risingCnt - riseBase, 32);
         checkOutput("freeRunJoy2", {16'd0, joystick2}, 32'h8000);
         lastDone = cycleCnt;
      end

      tieMode = 1;
      waitFrameDone(w);
      checkOutput("tie0Joy1", {16'd0, joystick1}, 32'hFFFF);
      checkOutput("tie0Joy2", {16'd0, joystick2}, 32'hFFFF);
      tieMode = 2;
      waitFrameDone(w);
      checkOutput("tie1Joy1", {16'd0, joystick1}, 32'h0000);
      checkOutput("tie1Joy2", {16'd0, joystick2}, 32'h0000);

      tieMode = 0;
      applyStimulus(16'hFF00, 16'hFF00);
      waitFrameDone(w);
      checkOutput("preRstJoy1", {16'd0, joystick1}, 32'h00FF);
      checkOutput("preRstJoy2", {16'd0, joystick2}, 32'h00FF);

      // Abort the next frame while it is shifting bit 10.
      applyStimulus(16'hEDCB, 16'h1234);
      waitLoadLevel(1'b0, w);
      riseBase = risingCnt;
      w = 0;
      while (risingCnt - riseBase < 10 && w < FRAME_CYC) begin
         @(negedge clk);
         w++;
      end
      checkOutput("reachBit10", risingCnt - riseBase, 10);
      doneBefore = doneCnt;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      relCycle = cycleCnt;
      checkResetState("midRst");
      waitLoadLevel(1'b0, w);
      checkOutput("restartLoadDelay", cycleCnt - relCycle, GAP_CYC);
      checkOutput("noDoneAfterRst", doneCnt - doneBefore, 0);
      waitFrameDone(w);
      checkOutput("restartJoy1", {16'd0, joystick1}, 32'h1234);
      checkOutput("restartJoy2", {16'd0, joystick2}, 32'hEDCB);
   endtask
`else
   task automatic runDebounceTests();
      int w;
      logic [15:0] seq [5];

      seq[0] = 16'hFFFE;
      seq[1] = 16'hFFFD;
      seq[2] = 16'hFFFE;
      seq[3] = 16'hFFFD;
      seq[4] = 16'hFFFD;
      applyStimulus(seq[0], 16'hFFFF);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         waitLoadLevel(1'b0, w);
         waitLoadLevel(1'b1, w);
         if (i < 4) applyStimulus(seq[i + 1], 16'hFFFF);
      end
      checkOutput("alternateNoDone", doneCnt, 0);
      checkOutput("alternateJoy1", {16'd0, joystick1}, 32'h0000);
      waitFrameDone(w);
      checkOutput("stableJoy1", {16'd0, joystick1}, 32'h0002);
      checkOutput("stableJoy2", {16'd0, joystick2}, 32'h0000);
      @(negedge clk);
      checkOutput("stableDoneCount", doneCnt, 1);
   endtask
`endif

   initial begin
      reset = 1'b1;
      repeat (10) @(negedge clk);
      checkResetState("rst");
`ifdef DB15_DEBOUNCE_EN
      runDebounceTests();
`else
      runMainTests();
`endif
      checkOutput("clkLoadOverlap", overlapCnt, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
